store_queue: RTL and testbench
==============================

Name: store_queue

Overview:
- Parametrised successor to the memory-stage store formatter.
- Accepts stores from the memory stage, lane-aligns data, generates byte strobes, checks alignment, and buffers entries in a DEPTH-entry FIFO.
- Drains entries to the data bus with a valid/ready handshake.
- Provides a combinational load-hazard query so the load path can stall on a pending overlapping store.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; 32 or 64 only.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  queue can accept; equals not full.
- in_addr  in  ADDR_WIDTH  byte address.
- in_data  in  DATA_WIDTH  store data, right-justified.
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- misalign  out  1  combinational; current request is misaligned or illegal.
- out_valid  out  1  head entry valid.
- out_ready  in  1  bus accepts head.
- out_addr  out  ADDR_WIDTH  head address, low log2(DATA_WIDTH/8) bits zero.
- out_data  out  DATA_WIDTH  lane-aligned head data.
- out_strobe  out  DATA_WIDTH/8  head byte enables.
- ld_addr  in  ADDR_WIDTH  load byte address to check.
- ld_hit  out  1  some valid entry has the same aligned address as ld_addr.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Define B = DATA_WIDTH/8 and L = log2(B). off = in_addr[L-1:0].
- Data formatting:
  - Lane data = in_data shifted left by off*8, truncated to DATA_WIDTH.
  - Strobe = ((1<<(1<<in_size))-1) << off.
  - Bytes outside the strobe are don't-care, but must be deterministic.
- misalign is asserted when any of these holds:
  - in_size=1 and in_addr[0]=1.
  - in_size=2 and in_addr[1:0]!=0.
  - in_size=3 and in_addr[2:0]!=0.
  - in_size=3 and DATA_WIDTH=32.
- misalign is purely combinational from in_valid, in_addr and in_size. It is 0 when in_valid=0.
- Push occurs when in_valid & in_ready & !misalign. A misaligned handshake is consumed and discarded: no entry is written and count is unchanged.
- Pop occurs when out_valid & out_ready.
- Outputs and flags:
  - out_valid = (count != 0).
  - out_* are driven from head-entry registers, with no combinational path from in_*.
  - Latency is 1 cycle: a push in cycle N gives out_valid in N+1 when the queue was empty.
  - in_ready = (count != DEPTH). There is no push-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy counter distinguishes full from empty.
- Output stability: while out_valid & !out_ready, out_addr, out_data and out_strobe hold stable.
- ld_hit is the OR over valid entries of (entry_addr[ADDR_WIDTH-1:L] == ld_addr[ADDR_WIDTH-1:L]). It is combinational and 0 when empty.
- Reset (resetn=0, asynchronous):
  - Pointers and count go to 0 and all entry valid bits clear.
  - out_valid=0 and ld_hit=0.
  - out_addr, out_data and out_strobe reset to 0.
  - Any in-flight entries are lost.
  - Deassertion is sampled on the next rising clk edge.

Optional Feature:
- Macro: STORE_QUEUE_MERGE_EN.
- Defined: a push whose aligned address equals the youngest valid entry's aligned address merges into that entry instead of allocating. Merge applies only when that entry is not the head or count>=2.
  - Merged data: per byte, the new byte where the new strobe is set, otherwise the old byte.
  - Merged strobe: old OR new.
  - count is unchanged.
  - in_ready may be 1 when full if the request merges. Merge eligibility is computed from in_addr combinationally.
- Undefined: every accepted aligned store allocates its own entry, and in_ready = !full strictly.

Test Plan:
- DATA_WIDTH=32, empty queue, push SB addr=0x1003 data=0x000000AB, out_ready=0:
  - Next cycle out_valid=1, out_addr=0x1000, out_data[31:24]=0xAB, out_strobe=4'b1000, count=1.
- Push SH addr=0x2001 -> misalign=1 same cycle, count stays 0, out_valid stays 0.
- Push SD with DATA_WIDTH=32 -> misalign=1 and the request is discarded.
- With DATA_WIDTH=64, push SD addr=0x10 data=0x1122334455667788 -> out_strobe=8'hFF and out_data unchanged.
- Fill and wrap, DEPTH=4, out_ready=0:
  - Push 4 SW to addresses 0x0, 0x4, 0x8, 0xC -> in_ready=0, count=4.
  - Then out_ready=1 for 4 cycles while pushing 0x10 -> heads appear in order 0x0, 0x4, 0x8, 0xC, then 0x10.
  - Pointers wrap to 0 with no lost entries.
- Load hazard, entry at 0x3000 pending:
  - ld_addr=0x3002 -> ld_hit=1.
  - ld_addr=0x3004 -> ld_hit=0.
  - Assert resetn=0 mid-drain -> out_valid=0, count=0, ld_hit=0 immediately, without waiting for a clock edge.
- STORE_QUEUE_MERGE_EN, head busy at 0x0:
  - Push SB 0x41 at 0x4001, then SB 0x42 at 0x4002 -> single entry with strobe 4'b0110 and data bytes [1]=0x41, [2]=0x42.
  - count=2 (head plus merged entry).

Source files
------------

// File: rtl/store_queue.sv
// Store queue: lane-aligns memory-stage stores, builds byte strobes, flags misaligned requests, buffers DEPTH entries for the data bus.
// Latency: 1 cycle from accepted push to out_valid on an empty queue; head outputs come straight from entry registers.
// Backpressure: in_ready = not full (no push-through on a full pop); the head holds stable while out_valid & !out_ready.
// Optional: define STORE_QUEUE_MERGE_EN to merge a store into the youngest non-head entry with the same aligned address.
module store_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [1:0]                    in_size,
  output logic                          misalign,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [DATA_WIDTH/8-1:0]       out_strobe,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  output logic                          ld_hit,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int L  = $clog2(B);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [B-1:0]          strb_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         youngest;
  logic [CW-1:0]         cnt_q;

  logic [L-1:0]          off;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [15:0]           strb_wide;
  logic [B-1:0]          lane_strobe;
  logic                  bad_align;
  logic                  full;
  logic                  merge_hit;
  logic                  accept;
  logic                  push;
  logic                  mrg;
  logic                  pop;
  logic                  unused_bits;

  assign off          = in_addr[L-1:0];
  assign aligned_addr = {in_addr[ADDR_WIDTH-1:L], {L{1'b0}}};
  assign lane_data    = in_data << {off, 3'b000};
  assign lane_strobe  = strb_wide[B-1:0];
  assign youngest     = wr_ptr - PW'(1);
  assign full         = (cnt_q == CW'(DEPTH));
  assign unused_bits  = ^{ld_addr[L-1:0], strb_wide[15:B]};

  // Byte-enable pattern for the access size, shifted into the addressed lane.
  always_comb begin
    strb_wide = 16'h0000;
    case (in_size)
      2'd0:    strb_wide = 16'h0001 << off;
      2'd1:    strb_wide = 16'h0003 << off;
      2'd2:    strb_wide = 16'h000F << off;
      default: strb_wide = 16'h00FF << off;
    endcase
  end

  // Alignment check; a dword can never fit a 32-bit bus, so it is always illegal there.
  always_comb begin
    bad_align = 1'b0;
    case (in_size)
      2'd1:    bad_align = in_addr[0];
      2'd2:    bad_align = |in_addr[1:0];
      2'd3:    bad_align = (|in_addr[2:0]) || (DATA_WIDTH == 32);
      default: bad_align = 1'b0;
    endcase
    misalign = in_valid & bad_align;
  end

`ifdef STORE_QUEUE_MERGE_EN
  // With two or more entries the youngest is never the head, so merging cannot disturb a head on the bus.
  assign merge_hit = in_valid & ~bad_align & (cnt_q >= CW'(2)) &
                     (addr_q[youngest][ADDR_WIDTH-1:L] == in_addr[ADDR_WIDTH-1:L]);
  assign in_ready  = ~full | merge_hit;
`else
  assign merge_hit = 1'b0;
  assign in_ready  = ~full;
`endif

  // A misaligned handshake is accepted and dropped; only aligned accepts touch the storage.
  assign accept    = in_valid & in_ready & ~misalign;
  assign push      = accept & ~merge_hit;
  assign mrg       = accept & merge_hit;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;
  assign out_addr   = addr_q[rd_ptr];
  assign out_data   = data_q[rd_ptr];
  assign out_strobe = strb_q[rd_ptr];

  // Load hazard: any valid entry sharing the bus-aligned word address.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i][ADDR_WIDTH-1:L] == ld_addr[ADDR_WIDTH-1:L])) begin
        ld_hit = 1'b1;
      end
    end
  end

  // Entry storage, pointers and occupancy; push and pop target different slots whenever both fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= aligned_addr;
        data_q[wr_ptr] <= lane_data;
        strb_q[wr_ptr] <= lane_strobe;
        vld_q[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (mrg) begin
        for (int b = 0; b < B; b++) begin
          if (lane_strobe[b]) begin
            data_q[youngest][b*8 +: 8] <= lane_data[b*8 +: 8];
          end
        end
        strb_q[youngest] <= strb_q[youngest] | lane_strobe;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: a 32-bit/DEPTH=4 instance and a 64-bit/DEPTH=2 instance.
// Inputs change 1 time unit after the rising edge; outputs are compared there too.
// Expected values are hand-computed constants.
module tb_store_queue;

  logic        clk;
  logic        resetn;
  int          n_chk;
  int          n_err;

  // 32-bit instance
  logic        in_valid, in_ready, misalign, out_valid, out_ready, ld_hit;
  logic [31:0] in_addr, in_data, out_addr, out_data, ld_addr;
  logic [1:0]  in_size;
  logic [3:0]  out_strobe;
  logic [2:0]  count;

  // 64-bit instance
  logic        w_in_valid, w_in_ready, w_misalign, w_out_valid, w_out_ready, w_ld_hit;
  logic [31:0] w_in_addr, w_out_addr, w_ld_addr;
  logic [63:0] w_in_data, w_out_data;
  logic [1:0]  w_in_size;
  logic [7:0]  w_out_strobe;
  logic [1:0]  w_count;

  store_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .in_size(in_size), .misalign(misalign),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_strobe(out_strobe), .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
  );

  store_queue #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(2)) dut64 (
    .clk(clk), .resetn(resetn),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_addr(w_in_addr), .in_data(w_in_data),
    .in_size(w_in_size), .misalign(w_misalign),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_addr(w_out_addr), .out_data(w_out_data),
    .out_strobe(w_out_strobe), .ld_addr(w_ld_addr), .ld_hit(w_ld_hit), .count(w_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    resetn = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    out_ready = 1'b0;
    ld_addr = 32'h0;
    w_in_valid = 1'b0; w_in_addr = 32'h0; w_in_data = 64'h0; w_in_size = 2'd0;
    w_out_ready = 1'b0; w_ld_addr = 32'h0;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_strobe", out_strobe, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    #9 resetn = 1'b1;
    step();

    // Store byte into the top lane
    drive(1'b1, 32'h1003, 32'h0000_00AB, 2'd0);
    #1 chk("sb_misalign", misalign, 1'b0);
    chk("sb_no_early_valid", out_valid, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("sb_out_valid", out_valid, 1'b1);
    chk("sb_out_addr", out_addr, 32'h1000);
    chk("sb_out_data", out_data, 32'hAB00_0000);
    chk("sb_out_strobe", out_strobe, 4'b1000);
    chk("sb_count", count, 3'd1);
    step();
    chk("sb_hold_data", out_data, 32'hAB00_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sb_popped", out_valid, 1'b0);

    // Misaligned half: flagged and discarded
    drive(1'b1, 32'h2001, 32'h0000_1234, 2'd1);
    #1 chk("sh_misalign", misalign, 1'b1);
    step();
    drive(1'b0, 32'h2001, 32'h0000_1234, 2'd1);
    #1 chk("sh_misalign_idle", misalign, 1'b0);
    chk("sh_count", count, 3'd0);
    chk("sh_out_valid", out_valid, 1'b0);

    // Misaligned word and any dword on the 32-bit bus
    drive(1'b1, 32'h2002, 32'h0, 2'd2);
    #1 chk("sw_misalign", misalign, 1'b1);
    drive(1'b1, 32'h10, 32'h5566_7788, 2'd3);
    #1 chk("sd32_misalign", misalign, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("sd32_count", count, 3'd0);

    // Aligned half in the upper lanes
    drive(1'b1, 32'h2002, 32'h0000_BEEF, 2'd1);
    #1 chk("sh2_misalign", misalign, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("sh2_data", out_data, 32'hBEEF_0000);
    chk("sh2_strobe", out_strobe, 4'b1100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Fill to DEPTH, then drain while a fifth store waits
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000_0000 | 32'(i), 2'd2);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    #1 chk("fill_count", count, 3'd4);
    chk("fill_in_ready", in_ready, 1'b0);
    ld_addr = 32'h0000_000A;
    #1 chk("fill_ld_hit", ld_hit, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k <= 1) drive(1'b1, 32'h10, 32'h2000_0010, 2'd2);
      else        drive(1'b0, 32'h0, 32'h0, 2'd0);
      #1 chk("drain_head", out_addr, 64'(k * 4));
      chk("drain_data", out_data, 64'(32'h1000_0000 | 32'(k)));
      chk("drain_in_ready", in_ready, (k != 0));
      step();
    end
    chk("wrap_count", count, 3'd1);
    chk("wrap_head", out_addr, 32'h10);
    chk("wrap_data", out_data, 32'h2000_0010);
    step();
    out_ready = 1'b0;
    chk("wrap_empty", out_valid, 1'b0);

    // Load hazard, then asynchronous reset mid-drain
    drive(1'b1, 32'h3000, 32'h55, 2'd2);
    step();
    drive(1'b1, 32'h3008, 32'h66, 2'd2);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    ld_addr = 32'h3002;
    #1 chk("ld_hit_same", ld_hit, 1'b1);
    ld_addr = 32'h3004;
    #1 chk("ld_hit_next", ld_hit, 1'b0);
    ld_addr = 32'h2FFC;
    #1 chk("ld_hit_prev", ld_hit, 1'b0);
    out_ready = 1'b1;
    step();
    chk("mid_count", count, 3'd1);
    ld_addr = 32'h3000;
    #1 chk("ld_hit_popped", ld_hit, 1'b0);
    ld_addr = 32'h300B;
    #1 chk("ld_hit_second", ld_hit, 1'b1);
    resetn = 1'b0;
    #1 chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_count", count, 3'd0);
    chk("arst_ld_hit", ld_hit, 1'b0);
    chk("arst_out_addr", out_addr, 32'h0);
    chk("arst_out_data", out_data, 32'h0);
    out_ready = 1'b0;
    #3 resetn = 1'b1;
    step();
    chk("post_rst_count", count, 3'd0);

    // Two bytes to one word behind a busy head
    drive(1'b1, 32'h0, 32'hDEAD_BEEF, 2'd2);
    step();
    drive(1'b1, 32'h4001, 32'h41, 2'd0);
    step();
    drive(1'b1, 32'h4002, 32'h42, 2'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    chk("m_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
`ifdef STORE_QUEUE_MERGE_EN
    chk("m_count", count, 3'd2);
    step();
    chk("m_addr", out_addr, 32'h4000);
    chk("m_strobe", out_strobe, 4'b0110);
    chk("m_data", out_data, 32'h0042_4100);
    step();
    chk("m_empty", count, 3'd0);
`else
    chk("nm_count", count, 3'd3);
    step();
    chk("nm_strobe1", out_strobe, 4'b0010);
    chk("nm_data1", out_data, 32'h0000_4100);
    step();
    chk("nm_strobe2", out_strobe, 4'b0100);
    chk("nm_data2", out_data, 32'h0042_0000);
    step();
    chk("nm_empty", count, 3'd0);
`endif
    out_ready = 1'b0;

    // 64-bit bus: dword and upper-half word
    w_in_valid = 1'b1; w_in_addr = 32'h10; w_in_data = 64'h1122_3344_5566_7788; w_in_size = 2'd3;
    #1 chk("w_sd_misalign", w_misalign, 1'b0);
    step();
    w_in_addr = 32'h1C; w_in_data = 64'h0000_0000_CAFE_F00D; w_in_size = 2'd2;
    chk("w_sd_strobe", w_out_strobe, 8'hFF);
    chk("w_sd_data", w_out_data, 64'h1122_3344_5566_7788);
    chk("w_sd_addr", w_out_addr, 32'h10);
    step();
    w_in_addr = 32'h14; w_in_size = 2'd3;
    #1 chk("w_sd_misalign_bad", w_misalign, 1'b1);
    chk("w_full_ready", w_in_ready, 1'b0);
    chk("w_full_count", w_count, 2'd2);
    w_in_valid = 1'b0;
    w_out_ready = 1'b1;
    step();
    chk("w_sw_addr", w_out_addr, 32'h18);
    chk("w_sw_strobe", w_out_strobe, 8'hF0);
    chk("w_sw_data", w_out_data, 64'hCAFE_F00D_0000_0000);
    step();
    w_out_ready = 1'b0;
    chk("w_empty", w_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
